// File: rtl/bus_arbiter_if.sv
// Bundle of requester-side and target-side signals for bus_arbiter.
//
// Handshake: the target takes a beat on any rising clk edge where
// bus_valid && bus_ready. While bus_valid is high and bus_ready is low,
// bus and bus_valid stay stable. beat_done pulses for one cycle after each
// completed beat.
interface bus_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] wdata;
  logic               bus_ready;
  logic [NREQ-1:0]    gnt;
  logic [DW-1:0]      bus;
  logic               bus_valid;
  logic               beat_done;
  logic               busy;
  logic               err;

  // Arbiter side
  modport master (
    input  req, wdata, bus_ready,
    output gnt, bus, bus_valid, beat_done, busy, err
  );

  // Requesters and target side
  modport slave (
    output req, wdata, bus_ready,
    input  gnt, bus, bus_valid, beat_done, busy, err
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter and burst sequencer for a shared registered data bus.
// Each grant moves up to MAXBURST beats from the owning requester to the
// target, and then the bus returns to IDLE for at least one cycle.
// Optional feature: define BUS_ARB_TIMEOUT_EN to abort a beat after the
// target has stalled it for TIMEOUT cycles and set the sticky err flag.
module bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int DW       = 8,
  parameter int MAXBURST = 4,
  parameter int TIMEOUT  = 15
) (
  input  logic           clk,
  input  logic           rstb,
  bus_arbiter_if.master  bif,
  output logic [1:0]     dbg_state_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAXBURST + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    XFER = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   last_owner_q, last_owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   bus_q, bus_d;
  logic            bus_valid_q, bus_valid_d;
  logic            beat_done_q, beat_done_d;

  logic [IW-1:0]   win_idx;
  logic [DW-1:0]   owner_data;
  logic            handshake;
  logic            last_beat;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0]   stall_q, stall_d;
  logic            err_q, err_d;
`endif

  assign owner_data = bif.wdata[int'(owner_q)*DW +: DW];
  assign handshake  = bus_valid_q && bif.bus_ready;
  assign last_beat  = ((cnt_q + CW'(1)) == CW'(MAXBURST)) || !bif.req[owner_q];

  // Round-robin pick: first pending request after last_owner, wrapping.
  always_comb begin
    int idx;
    logic found;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last_owner_q) + i) % NREQ;
      if (!found && bif.req[idx]) begin
        found   = 1'b1;
        win_idx = IW'(idx);
      end
    end
  end

  // Next-state and registered-output logic for the IDLE/LOAD/XFER sequencer.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    bus_d        = bus_q;
    bus_valid_d  = bus_valid_q;
    beat_done_d  = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
    stall_d      = stall_q;
    err_d        = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (|bif.req) begin
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          owner_d        = win_idx;
          cnt_d          = '0;
          state_d        = LOAD;
        end
      end
      LOAD: begin
        if (bif.req[owner_q]) begin
          bus_d       = owner_data;
          bus_valid_d = 1'b1;
          state_d     = XFER;
`ifdef BUS_ARB_TIMEOUT_EN
          stall_d     = '0;
`endif
        end else begin
          // Requester withdrew before its first beat: release without a beat.
          gnt_d        = '0;
          last_owner_d = owner_q;
          state_d      = IDLE;
        end
      end
      XFER: begin
        if (handshake) begin
          beat_done_d = 1'b1;
          cnt_d       = cnt_q + CW'(1);
`ifdef BUS_ARB_TIMEOUT_EN
          stall_d     = '0;
`endif
          if (last_beat) begin
            bus_valid_d  = 1'b0;
            gnt_d        = '0;
            last_owner_d = owner_q;
            state_d      = IDLE;
          end else begin
            // Next beat goes straight onto the bus, no bubble.
            bus_d = owner_data;
          end
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else if (stall_q == SW'(TIMEOUT - 1)) begin
          // Target stalled too long: drop the beat and flag it.
          bus_valid_d  = 1'b0;
          gnt_d        = '0;
          last_owner_d = owner_q;
          state_d      = IDLE;
          err_d        = 1'b1;
          stall_d      = '0;
        end else begin
          stall_d = stall_q + SW'(1);
        end
`endif
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = '0;
        bus_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any beat in flight.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      owner_q      <= '0;
      last_owner_q <= IW'(NREQ - 1);
      cnt_q        <= '0;
      bus_q        <= '0;
      bus_valid_q  <= 1'b0;
      beat_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      bus_q        <= bus_d;
      bus_valid_q  <= bus_valid_d;
      beat_done_q  <= beat_done_d;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  // Stall counter and sticky error flag.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end
  assign bif.err = err_q;
`else
  assign bif.err = 1'b0;
`endif

  assign bif.gnt       = gnt_q;
  assign bif.bus       = bus_q;
  assign bif.bus_valid = bus_valid_q;
  assign bif.beat_done = beat_done_q;
  assign bif.busy      = (state_q != IDLE);
  assign dbg_state_o   = state_q;

endmodule
